game_key_conditioner: RTL

- Conditions the raw push-button that drives the game master FSM's `key` input.
- Synchronizes, polarity-normalizes and debounces the raw key, then provides:
  - a clean debounced level (`key`) for the FSM;
  - one-cycle press and release pulses;
  - a wrapping press counter for the score/debug display.
- Sits between the board button pin and the game master FSM, in the same clock domain.

---
 rtl/game_key_conditioner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/game_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : game_key_conditioner
//  Description : Conditions the raw game push-button for the game master FSM.
//                Two-flop synchronizer, polarity normalization, counter-based
//                debounce FSM, one-cycle press/release pulses and a wrapping
//                8-bit press counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   system clock
//    reset_n          in   asynchronous active-low reset
//    key_raw          in   unsynchronized button pin
//    key              out  debounced level, 1 = pressed
//    key_pressed      out  one-cycle pulse per accepted press (and repeat)
//    key_released     out  one-cycle pulse per accepted release
//    key_press_count  out  number of key_pressed pulses, modulo 256
//  Configuration
//    GAME_KEY_AUTOREPEAT_EN : when defined, a held key produces extra
//    key_pressed pulses REPEAT_DELAY cycles after the press pulse and then
//    every REPEAT_PERIOD cycles. Undefined: one pulse per accepted press.
// ============================================================================
module game_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_raw,
    output logic       key,
    output logic       key_pressed,
    output logic       key_released,
    output logic [7:0] key_press_count
);

    // Raw pin level while the button is released; the synchronizer resets
    // to it so leaving reset never looks like an edge.
    localparam logic             c_RAW_RELEASED = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] c_CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Parameter legality, checked at elaboration.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must lie in 2 .. 2**20");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             key_q;
    logic             pressed_q;
    logic             released_q;
    logic [7:0]       count_q;
    logic             key_norm;

`ifdef GAME_KEY_AUTOREPEAT_EN
    localparam int               c_REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                             : REPEAT_PERIOD;
    localparam int               c_REP_W    = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_REP_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_REP_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    // Cycles remaining until the next repeat pulse; only moves in PRESSED,
    // so a bounce through RELEASE_WAIT freezes it rather than restarting it.
    logic [c_REP_W-1:0] rep_cnt_q;
`endif

    // 1 = pressed, independent of board polarity.
    assign key_norm = sync2_q ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= c_RAW_RELEASED;
            sync2_q    <= c_RAW_RELEASED;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            key_q      <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            count_q    <= '0;
`ifdef GAME_KEY_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (key_norm) begin
                        state_q <= ST_PRESS_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!key_norm) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q   <= ST_PRESSED;
                        cnt_q     <= '0;
                        key_q     <= 1'b1;
                        pressed_q <= 1'b1;
                        count_q   <= count_q + 8'd1;
`ifdef GAME_KEY_AUTOREPEAT_EN
                        rep_cnt_q <= c_REP_DELAY_LAST;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_PRESSED: begin
                    if (!key_norm) begin
                        state_q <= ST_RELEASE_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
`ifdef GAME_KEY_AUTOREPEAT_EN
                    if (rep_cnt_q == '0) begin
                        pressed_q <= 1'b1;
                        count_q   <= count_q + 8'd1;
                        rep_cnt_q <= c_REP_PERIOD_LAST;
                    end else begin
                        rep_cnt_q <= rep_cnt_q - c_REP_W'(1);
                    end
`endif
                end

                ST_RELEASE_WAIT: begin
                    if (key_norm) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        key_q      <= 1'b0;
                        released_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key             = key_q;
    assign key_pressed     = pressed_q;
    assign key_released    = released_q;
    assign key_press_count = count_q;

endmodule
`default_nettype wire
